// File: rtl/load_store_unit_if.sv
// CPU-side request/response bundle of the load/store unit.
// The master drives requests; the slave (the LSU) drives ready and the completion.
interface load_store_unit_if #(parameter int ADDR_W = 15);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       load_data;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, load_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, load_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide DataMemory with a
// combinational read port; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    cpu,
  output logic [ADDR_W-1:0]   data_address,
  output logic                write_en,
  output logic [31:0]         write_data,
  input  logic [31:0]         read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE_RD, STORE_WR, DONE} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        write_en_q;
  logic        req_err;
  logic        accept;

  assign cpu.req_ready = (state == IDLE);
  assign accept        = cpu.req_valid && (state == IDLE);

  assign req_err = (cpu.req_size == 2'b11) ||
                   (cpu.req_size == 2'b01 && cpu.req_addr[0]) ||
                   (cpu.req_size == 2'b10 && cpu.req_addr[1:0] != 2'b00);

  // Memory writes on the same edge reset is sampled, so a store caught in
  // STORE_WR must be killed combinationally to keep it from landing.
  assign write_en = write_en_q & ~reset;

  function automatic logic [31:0] extract(logic [31:0] w, logic [1:0] sz,
                                          logic [1:0] off, logic uns);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    if (sz == 2'b00) return {{24{~uns & sh[7]}}, sh[7:0]};
    if (sz == 2'b01) return {{16{~uns & sh[15]}}, sh[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] w, logic [31:0] d,
                                        logic [1:0] sz, logic [1:0] off);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) m[{off, 3'b000} +: 8]         = d[7:0];
    else             m[{off[1], 4'b0000} +: 16]    = d[15:0];
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      off_q          <= 2'b00;
      wdata_q        <= '0;
      write_en_q     <= 1'b0;
      write_data     <= '0;
      data_address   <= '0;
      cpu.resp_valid <= 1'b0;
      cpu.resp_err   <= 1'b0;
      cpu.load_data  <= '0;
    end else begin
      write_en_q     <= 1'b0;
      cpu.resp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          size_q       <= cpu.req_size;
          uns_q        <= cpu.req_unsigned;
          off_q        <= cpu.req_addr[1:0];
          wdata_q      <= cpu.req_wdata;
          data_address <= cpu.req_addr[ADDR_W+1:2];
          cpu.resp_err <= req_err;
          if (req_err) begin
            state          <= DONE;
            cpu.resp_valid <= 1'b1;
            cpu.load_data  <= '0;
          end else if (!cpu.req_write) begin
            state <= LOAD;
          end else if (cpu.req_size == 2'b10) begin
            state      <= STORE_WR;
            write_en_q <= 1'b1;
            write_data <= cpu.req_wdata;
          end else begin
            state <= STORE_RD;
          end
        end
        LOAD: begin
          cpu.load_data  <= extract(read_data, size_q, off_q, uns_q);
          cpu.resp_valid <= 1'b1;
          state          <= DONE;
        end
        STORE_RD: begin
          write_data <= merge(read_data, wdata_q, size_q, off_q);
          write_en_q <= 1'b1;
          state      <= STORE_WR;
        end
        STORE_WR: begin
          cpu.resp_valid <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          cpu.resp_err <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: a byte-array memory model predicts every write and response;
// a negedge monitor pops and compares whenever the DUT writes or responds.
module tb_load_store_unit;
  localparam int ADDR_W = 15;
  localparam int NBYTES = 1 << (ADDR_W + 2);

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] data_address;
  logic write_en;
  logic [31:0] write_data;
  logic [31:0] read_data;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .cpu(bus),
    .data_address(data_address), .write_en(write_en),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // DataMemory: combinational read, write on rising edge
  logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};
  assign read_data = mem[data_address];
  always @(posedge clk) if (write_en) mem[data_address] <= write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data; logic err; int cyc; logic chk_lit; logic [31:0] lit;
  } resp_t;
  typedef struct {
    logic [31:0] wa; logic [31:0] wd; int cyc; logic chk_lit; logic [31:0] lit;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  int compared = 0, mismatched = 0;
  int wr_seen = 0, wr_pushed = 0, last_resp_cyc = -10;
  logic [7:0]  rb [0:NBYTES-1];
  logic [31:0] last_ld;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor
  resp_t r;
  wr_t   w;
  always @(negedge clk) begin
    if (write_en) begin
      wr_seen++;
      if (wq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", data_address, write_data);
      end else begin
        w = wq.pop_front();
        check("wr_addr", 32'(data_address), w.wa);
        check("wr_data", write_data, w.wd);
        check("wr_cycle", cyc, w.cyc);
        if (w.chk_lit) check("wr_literal", write_data, w.lit);
      end
    end
    if (bus.resp_valid) begin
      last_resp_cyc = cyc;
      if (rq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_resp: got err %b data %h expected none", bus.resp_err, bus.load_data);
      end else begin
        r = rq.pop_front();
        check("resp_err", 32'(bus.resp_err), 32'(r.err));
        check("load_data", bus.load_data, r.data);
        check("resp_cycle", cyc, r.cyc);
        if (r.chk_lit) check("load_literal", bus.load_data, r.lit);
      end
    end
  end

  // Drive one request, wait for acceptance, and push the model's predictions.
  task automatic issue(bit wr, logic [1:0] sz, bit uns, int a, logic [31:0] wd,
                       bit chk, logic [31:0] lit, bit b2b);
    int t, n, acc, base;
    bit err;
    logic [31:0] val;
    resp_t re;
    wr_t we;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = (ADDR_W+2)'(a); bus.req_wdata = wd;
    t = 0;
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout: got no req_ready expected within 20 cycles");
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (b2b) check("b2b_accept_cycle", acc, last_resp_cyc + 1);
    n   = 1 << sz;
    err = (sz == 2'b11) || (a % n != 0);
    re.chk_lit = chk && !wr; re.lit = lit;
    if (err) begin
      last_ld = '0; re.cyc = acc + 1;
    end else if (!wr) begin
      val = '0;
      for (int i = 0; i < n; i++) val |= 32'(rb[a+i]) << (8*i);
      if (!uns && n < 4 && val[8*n-1]) val |= 32'hFFFF_FFFF << (8*n);
      last_ld = val; re.cyc = acc + 2;
    end else begin
      for (int i = 0; i < n; i++) rb[a+i] = wd[8*i +: 8];
      base = a & ~3;
      we.wa = 32'(a >> 2);
      we.wd = {rb[base+3], rb[base+2], rb[base+1], rb[base]};
      we.cyc = acc + ((n == 4) ? 1 : 2);
      we.chk_lit = chk; we.lit = lit;
      wq.push_back(we); wr_pushed++;
      re.cyc = acc + ((n == 4) ? 2 : 3);
    end
    re.err = err; re.data = last_ld;
    rq.push_back(re);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: got %0d responses pending expected 0", rq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a, widx;
    logic [1:0] sz;
    for (int i = 0; i < NBYTES; i++) rb[i] = 8'h00;
    last_ld = '0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
    bus.req_unsigned = 0; bus.req_addr = '0; bus.req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_data_address", 32'(data_address), 32'd0);
    check("rst_load_data", bus.load_data, 32'd0);
    reset = 1'b0;

    // word store then load
    issue(1, 2'b10, 0, 32'h4, 32'h1234_5678, 1, 32'h1234_5678, 0);
    issue(0, 2'b10, 0, 32'h4, 32'h0, 1, 32'h1234_5678, 0);
    // byte store read-modify-write
    issue(1, 2'b10, 0, 32'h0, 32'h8765_4321, 0, 32'h0, 0);
    issue(1, 2'b00, 0, 32'h2, 32'h0000_00AB, 1, 32'h87AB_4321, 0);
    // sign/zero extension
    issue(1, 2'b10, 0, 32'h0, 32'h80FF_7F01, 0, 32'h0, 0);
    issue(0, 2'b00, 0, 32'h2, 32'h0, 1, 32'hFFFF_FFFF, 0);
    issue(0, 2'b01, 1, 32'h2, 32'h0, 1, 32'h0000_80FF, 0);
    issue(0, 2'b01, 0, 32'h0, 32'h0, 1, 32'h0000_7F01, 0);
    // errors
    issue(0, 2'b10, 0, 32'h6, 32'h0, 1, 32'h0, 0);
    issue(0, 2'b11, 0, 32'h0, 32'h0, 1, 32'h0, 0);
    issue(1, 2'b01, 0, 32'h1, 32'hFFFF, 0, 32'h0, 0);
    drain();

    // reset during STORE_RD of a byte store: nothing may complete
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = (ADDR_W+2)'(1); bus.req_wdata = 32'h55;
    check("rd_abort_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_ld = '0;
    @(negedge clk);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_write_en", 32'(write_en), 32'd0);
    issue(0, 2'b10, 0, 32'h0, 32'h0, 1, 32'h80FF_7F01, 0);
    drain();

    // back-to-back stores and loads
    issue(1, 2'b10, 0, 32'h8, 32'hABCD_EF01, 0, 32'h0, 0);
    issue(1, 2'b10, 0, 32'hC, 32'h9876_5432, 0, 32'h0, 1);
    issue(0, 2'b10, 0, 32'h8, 32'h0, 1, 32'hABCD_EF01, 1);
    issue(0, 2'b10, 0, 32'hC, 32'h0, 1, 32'h9876_5432, 1);
    // highest word address
    issue(1, 2'b10, 0, NBYTES - 4, 32'hCAFE_F00D, 0, 32'h0, 0);
    issue(1, 2'b00, 0, NBYTES - 1, 32'h0000_0042, 1, 32'h42FE_F00D, 0);
    issue(0, 2'b01, 0, NBYTES - 2, 32'h0, 1, 32'h0000_42FE, 0);
    drain();

    // random traffic over a small window plus the top word
    for (int k = 0; k < 300; k++) begin
      widx = $urandom_range(0, 20);
      if (widx > 15) widx = (1 << ADDR_W) - 1;
      a  = widx * 4 + (($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), 0, 32'h0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("write_pulse_count", wr_seen, wr_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
